ysyx_2022040010_bus_arbiter: RTL

Sequential arbiter sharing one external memory bus between the instruction-fetch requester (IF) and the data requester (EX/MEM). It sits between the five-stage core and the bus/uncache side, replacing separate isram/dsram ports. It serialises requests through a small FSM, returns a registered one-cycle `done` with read data to the winner, and raises a stall request while any requester is waiting.

---
 rtl/ysyx_2022040010_bus_arbiter_pkg.sv | 30 +++
 rtl/ysyx_2022040010_bus_arbiter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/ysyx_2022040010_bus_arbiter_pkg.sv
// Shared constants for the IF / EX-MEM bus arbiter.
//   - FSM state encoding (2 bits)
//   - grant identifiers
//   - fixed instruction-side request fields
//   - round-robin grant picker
package ysyx_2022040010_bus_arbiter_pkg;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic GntInst = 1'b0;
  localparam logic GntData = 1'b1;

  localparam int unsigned InstW   = 32;
  localparam logic [7:0]  InstSel = 8'hFF;

  // On a tie the requester that did not win last time gets the bus.
  function automatic logic pick_grant(input logic inst_req, input logic data_req,
                                      input logic last_grant);
    if (inst_req && data_req) begin
      return (last_grant == GntInst) ? GntData : GntInst;
    end else if (data_req) begin
      return GntData;
    end
    return GntInst;
  endfunction

endpackage

// File: rtl/ysyx_2022040010_bus_arbiter.sv
// Sequential arbiter sharing one memory bus between instruction fetch and data access.
// One transaction at a time: IDLE (grant) -> REQ (valid/ready) -> WAIT (rvalid) -> DONE.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   i_req/i_addr             instruction read request (level, held until i_done)
//   i_done/i_rdata           one-cycle completion pulse and 32-bit instruction
//   d_req/d_we/d_addr/...    data request (level, held until d_done)
//   d_done/d_rdata           one-cycle completion pulse and read data (0 for writes)
//   bus_*                    latched request towards the bus and its response
//   stallreq_for_bus         stall request while any requester is still waiting
module ysyx_2022040010_bus_arbiter
  import ysyx_2022040010_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [InstW-1:0]  i_rdata,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [7:0]        d_sel,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,

  output logic              bus_valid,
  input  logic              bus_ready,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [7:0]        bus_sel,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata,

  output logic              stallreq_for_bus
);

  logic [1:0]        state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        sel_q, sel_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    sel_d        = sel_q;
    rdata_d      = rdata_q;

    unique case (state_q)
      StIdle: begin
        if (i_req || d_req) begin
          gnt_d   = pick_grant(i_req, d_req, last_grant_q);
          state_d = StReq;
          if (gnt_d == GntData) begin
            we_d    = d_we;
            addr_d  = d_addr;
            wdata_d = d_wdata;
            sel_d   = d_sel;
          end else begin
            we_d    = 1'b0;
            addr_d  = i_addr;
            wdata_d = '0;
            sel_d   = InstSel;
          end
        end
      end
      StReq: begin
        if (bus_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        // Writes also wait here for the bus acknowledge.
        if (bus_rvalid) begin
          rdata_d = bus_rdata;
          state_d = StDone;
        end
      end
      StDone: begin
        last_grant_d = gnt_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      gnt_q        <= GntInst;
      last_grant_q <= GntInst;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      sel_q        <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      sel_q        <= sel_d;
      rdata_q      <= rdata_d;
    end
  end

  assign bus_valid = (state_q == StReq);
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_sel   = sel_q;

  assign i_done = (state_q == StDone) && (gnt_q == GntInst);
  assign d_done = (state_q == StDone) && (gnt_q == GntData);

  // Address bit 2 selects which half of the 64-bit beat holds the instruction.
  always_comb begin
    i_rdata = '0;
    if (i_done) begin
      i_rdata = addr_q[2] ? rdata_q[2*InstW-1:InstW] : rdata_q[InstW-1:0];
    end
  end

  assign d_rdata = (d_done && !we_q) ? rdata_q : '0;

  assign stallreq_for_bus = (i_req && !i_done) || (d_req && !d_done);

endmodule
